// File: rtl/ghost_motion_ctrl_if.sv
`timescale 1ns/1ps
// Video-slot bus: one request per cycle, combinational write strobe.
// The CPU side drives it as master; the sprite-core side is driven by the controller.
interface ghost_motion_ctrl_if;
  logic        cs;
  logic        write;
  logic [13:0] addr;
  logic [31:0] wr_data;

  modport master (output cs, write, addr, wr_data);
  modport slave  (input  cs, write, addr, wr_data);
endinterface

// File: rtl/ghost_motion_ctrl.sv
`timescale 1ns/1ps
// Ghost sprite motion sequencer: per-frame position step with edge bounce, arbitrated onto the sprite slot port.
// Optional GHOST_CPU_SNOOP_EN: granted CPU writes to x0/y0 also teleport the internal position.
//
// state | meaning
// IDLE  | waiting for a frame tick
// CALC  | one cycle, step px/py and bounce velocities
// WR_X  | write px to x0 once the CPU is not using the slot port
// WR_Y  | write py to y0 once the CPU is not using the slot port
module ghost_motion_ctrl #(
  parameter int H_MAX    = 640,
  parameter int V_MAX    = 480,
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [10:0]                x_i,
  input  logic [10:0]                y_i,
  input  logic                       ctrl_wr_i,
  input  logic [1:0]                 ctrl_addr_i,
  input  logic [31:0]                ctrl_data_i,
  ghost_motion_ctrl_if.slave         cpu_if,
  ghost_motion_ctrl_if.master        core_if,
  output logic                       busy_o,
  output logic                       overrun_o
);

  localparam logic [10:0] X_LIM   = 11'(H_MAX - SPRITE_W);
  localparam logic [10:0] Y_LIM   = 11'(V_MAX - SPRITE_H);
  localparam logic [13:0] ADDR_X0 = 14'h2001;
  localparam logic [13:0] ADDR_Y0 = 14'h2002;

  typedef enum logic [1:0] {IDLE, CALC, WR_X, WR_Y} state_t;

  typedef struct packed {
    logic [3:0]  v;
    logic [10:0] p;
  } axis_t;

  // Position stays in 0..LIM, so a 12-bit sum never overflows; bit 11 flags a negative result.
  function automatic axis_t step_axis(input logic [10:0] p, input logic [3:0] v,
                                      input logic [10:0] lim);
    logic [11:0] n;
    axis_t       r;
    n   = {1'b0, p} + {{8{v[3]}}, v};
    r.v = v;
    r.p = n[10:0];
    if (n[11]) begin
      r.p = '0;
      r.v = 4'd0 - v;
    end else if (n[10:0] > lim) begin
      r.p = lim;
      r.v = 4'd0 - v;
    end
    return r;
  endfunction

`ifdef GHOST_CPU_SNOOP_EN
  function automatic logic [10:0] clamp(input logic [10:0] v, input logic [10:0] lim);
    return (v > lim) ? lim : v;
  endfunction
`endif

  state_t      state_q, state_d;
  logic        cond, cond_q, tick;
  logic        en_q, en_d;
  logic [3:0]  dx_q, dx_d, dy_q, dy_d;
  logic [10:0] px_q, px_d, py_q, py_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;
  axis_t       nx, ny;
  logic        unused_ctrl;

  assign unused_ctrl = ^ctrl_data_i[31:4];

  // Edge detect makes the tick independent of how many clk cycles a pixel lasts.
  assign cond = (x_i == 11'd0) && (y_i == 11'(V_MAX));
  assign tick = cond && !cond_q;

  assign nx = step_axis(px_q, dx_q, X_LIM);
  assign ny = step_axis(py_q, dy_q, Y_LIM);

  always_comb begin
    state_d         = state_q;
    en_d            = en_q;
    dx_d            = dx_q;
    dy_d            = dy_q;
    px_d            = px_q;
    py_d            = py_q;
    overrun_d       = overrun_q;
    core_if.cs      = 1'b0;
    core_if.write   = 1'b0;
    core_if.addr    = '0;
    core_if.wr_data = '0;

    if (cpu_if.cs) begin
      core_if.cs      = 1'b1;
      core_if.write   = cpu_if.write;
      core_if.addr    = cpu_if.addr;
      core_if.wr_data = cpu_if.wr_data;
    end

    case (state_q)
      IDLE: if (tick && en_q) state_d = CALC;
      CALC: begin
        px_d    = nx.p;
        dx_d    = nx.v;
        py_d    = ny.p;
        dy_d    = ny.v;
        state_d = WR_X;
      end
      WR_X: if (!cpu_if.cs) begin
        core_if.cs      = 1'b1;
        core_if.write   = 1'b1;
        core_if.addr    = ADDR_X0;
        core_if.wr_data = {21'b0, px_q};
        state_d         = WR_Y;
      end
      WR_Y: if (!cpu_if.cs) begin
        core_if.cs      = 1'b1;
        core_if.write   = 1'b1;
        core_if.addr    = ADDR_Y0;
        core_if.wr_data = {21'b0, py_q};
        state_d         = IDLE;
      end
      default: state_d = IDLE;
    endcase

`ifdef GHOST_CPU_SNOOP_EN
    // Placed after CALC so a coincident teleport overrides the computed step.
    if (cpu_if.cs && cpu_if.write && (cpu_if.addr == ADDR_X0))
      px_d = clamp(cpu_if.wr_data[10:0], X_LIM);
    if (cpu_if.cs && cpu_if.write && (cpu_if.addr == ADDR_Y0))
      py_d = clamp(cpu_if.wr_data[10:0], Y_LIM);
`endif

    if (ctrl_wr_i) begin
      case (ctrl_addr_i)
        2'd0: begin
          en_d = ctrl_data_i[0];
          if (ctrl_data_i[1]) overrun_d = 1'b0;
        end
        2'd1:    dx_d = ctrl_data_i[3:0];
        2'd2:    dy_d = ctrl_data_i[3:0];
        default: ;
      endcase
    end

    // A dropped tick must not be lost to a same-cycle clear.
    if (tick && busy_q) overrun_d = 1'b1;

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cond_q    <= 1'b0;
      en_q      <= 1'b0;
      dx_q      <= 4'd1;
      dy_q      <= 4'd1;
      px_q      <= '0;
      py_q      <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cond_q    <= cond;
      en_q      <= en_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      px_q      <= px_d;
      py_q      <= py_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
    end
  end

  assign busy_o    = busy_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_ghost_motion_ctrl.sv
`timescale 1ns/1ps
// Directed bench for ghost_motion_ctrl: timing, bounce, CPU priority, overrun, reset and snoop.
module tb_ghost_motion_ctrl;
  logic        clk;
  logic        reset;
  logic [10:0] x, y;
  logic        ctrl_wr;
  logic [1:0]  ctrl_addr;
  logic [31:0] ctrl_data;
  logic        busy, overrun;
  int          n_checks = 0;
  int          n_fail   = 0;

  ghost_motion_ctrl_if cpu_bus ();
  ghost_motion_ctrl_if core_bus ();

  ghost_motion_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .x_i         (x),
    .y_i         (y),
    .ctrl_wr_i   (ctrl_wr),
    .ctrl_addr_i (ctrl_addr),
    .ctrl_data_i (ctrl_data),
    .cpu_if      (cpu_bus),
    .core_if     (core_bus),
    .busy_o      (busy),
    .overrun_o   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ctrl_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    ctrl_wr = 1'b1; ctrl_addr = a; ctrl_data = d;
    @(negedge clk);
    ctrl_wr = 1'b0; ctrl_addr = '0; ctrl_data = '0;
  endtask

  task automatic cond_on();
    x = 11'd0; y = 11'd480;
  endtask

  task automatic cond_off();
    x = 11'd1; y = 11'd0;
  endtask

  task automatic quiet_frame();
    @(negedge clk); cond_on();
    @(negedge clk); cond_off();
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_check(input string tag, input logic [31:0] ex, input logic [31:0] ey);
    @(negedge clk); cond_on();
    @(negedge clk); cond_off(); #1;
    check({tag, "_calc_busy"}, 32'(busy), 32'd1);
    check({tag, "_calc_cs"}, 32'(core_bus.cs), 32'd0);
    @(negedge clk); #1;
    check({tag, "_x_cs"}, 32'({core_bus.cs, core_bus.write}), 32'd3);
    check({tag, "_x_addr"}, 32'(core_bus.addr), 32'h2001);
    check({tag, "_x_data"}, core_bus.wr_data, ex);
    @(negedge clk); #1;
    check({tag, "_y_addr"}, 32'(core_bus.addr), 32'h2002);
    check({tag, "_y_data"}, core_bus.wr_data, ey);
    check({tag, "_y_busy"}, 32'(busy), 32'd1);
    @(negedge clk); #1;
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    check({tag, "_idle_cs"}, 32'(core_bus.cs), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    x = '0; y = '0;
    ctrl_wr = 1'b0; ctrl_addr = '0; ctrl_data = '0;
    cpu_bus.cs = 1'b0; cpu_bus.write = 1'b0; cpu_bus.addr = '0; cpu_bus.wr_data = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    check("rst_core_cs", 32'(core_bus.cs), 32'd0);
    reset = 1'b0;

    // Tick with en=0 must not start a sequence
    @(negedge clk); cond_on();
    @(negedge clk); cond_off(); #1;
    check("en0_busy", 32'(busy), 32'd0);
    @(negedge clk); #1;
    check("en0_cs", 32'(core_bus.cs), 32'd0);

    ctrl_write(2'd1, 32'd3);
    ctrl_write(2'd2, 32'd2);
    ctrl_write(2'd3, 32'hF);
    ctrl_write(2'd0, 32'd1);

    frame_check("f1", 32'd3, 32'd2);
    for (int i = 0; i < 201; i++) quiet_frame();
    // px 606 + 3 exceeds 608: clamp and reverse
    frame_check("bounce", 32'd608, 32'd406);
    frame_check("after_bounce", 32'd605, 32'd408);

    // CPU holds the slot port for 5 cycles starting at T+2
    @(negedge clk); cond_on();
    @(negedge clk); cond_off();
    cpu_bus.write = 1'b1; cpu_bus.addr = 14'h0100; cpu_bus.wr_data = 32'hDEADBEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); cpu_bus.cs = 1'b1; #1;
      check("cpu_addr", 32'(core_bus.addr), 32'h0100);
      check("cpu_data", core_bus.wr_data, 32'hDEADBEEF);
      check("cpu_busy", 32'(busy), 32'd1);
    end
    @(negedge clk); cpu_bus.cs = 1'b0; cpu_bus.write = 1'b0; #1;
    check("late_x_addr", 32'(core_bus.addr), 32'h2001);
    check("late_x_data", core_bus.wr_data, 32'd602);
    @(negedge clk); #1;
    check("late_y_addr", 32'(core_bus.addr), 32'h2002);
    check("late_y_data", core_bus.wr_data, 32'd410);
    @(negedge clk); #1;
    check("late_idle", 32'(busy), 32'd0);

    // Second tick at T+2 is dropped and flags overrun
    @(negedge clk); cond_on();
    @(negedge clk); cond_off();
    @(negedge clk); cond_on(); #1;
    check("ovr_x_data", core_bus.wr_data, 32'd599);
    check("ovr_pre", 32'(overrun), 32'd0);
    @(negedge clk); #1;
    check("ovr_set", 32'(overrun), 32'd1);
    check("ovr_y_data", core_bus.wr_data, 32'd412);
    @(negedge clk); cond_off(); #1;
    check("ovr_idle", 32'(busy), 32'd0);
    @(negedge clk); #1;
    check("ovr_sticky", 32'(overrun), 32'd1);
    check("ovr_no_restart", 32'(busy), 32'd0);
    ctrl_write(2'd0, 32'd3);
    #1;
    check("ovr_clear", 32'(overrun), 32'd0);

    // Reset during WR_X
    @(negedge clk); cond_on();
    @(negedge clk); cond_off();
    @(negedge clk); #1;
    check("rstmid_x_cs", 32'(core_bus.cs), 32'd1);
    check("rstmid_x_data", core_bus.wr_data, 32'd596);
    reset = 1'b1; #1;
    check("rstmid_cs", 32'(core_bus.cs), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    @(negedge clk); reset = 1'b0;
    ctrl_write(2'd0, 32'd1);
    frame_check("post_rst", 32'd1, 32'd1);

    // CPU write to x0 with 700: teleports only when snooping is built in
    @(negedge clk);
    cpu_bus.cs = 1'b1; cpu_bus.write = 1'b1; cpu_bus.addr = 14'h2001; cpu_bus.wr_data = 32'd700; #1;
    check("snoop_pass_addr", 32'(core_bus.addr), 32'h2001);
    check("snoop_pass_data", core_bus.wr_data, 32'd700);
    @(negedge clk);
    cpu_bus.cs = 1'b0; cpu_bus.write = 1'b0; cpu_bus.addr = '0; cpu_bus.wr_data = '0;
`ifdef GHOST_CPU_SNOOP_EN
    frame_check("snoop1", 32'd608, 32'd2);
    frame_check("snoop2", 32'd607, 32'd3);
`else
    frame_check("nosnoop1", 32'd2, 32'd2);
    frame_check("nosnoop2", 32'd3, 32'd3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
